// File: rtl/prio_irq_enc_pkg.sv
// Shared types and helpers for the registered priority interrupt encoder
// and the combinational picker it uses.
package prio_irq_enc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  // Index width for an N-line encoder; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_irq_enc_pick.sv
// Combinational picker: selects one set bit of cand relative to ptr.
// Round-robin scans upward from ptr; fixed mode (ptr tied to 0) scans downward.
module prio_pick
  import prio_irq_enc_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 3,
  parameter int unsigned RR = MODE_FIXED
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  localparam logic [W:0] LAST = (W+1)'(N - 1);
  localparam logic [W:0] SPAN = (W+1)'(N);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;

  // rot[k] is cand[(ptr + k) mod N]; rotating through a doubled copy avoids
  // any variable bit-select and works for non power-of-two N.
  always_comb begin
    rot = N'({cand, cand} >> ptr);
    any = |rot;
    off = '0;
    if (RR == MODE_RR) begin
      for (int unsigned k = N; k > 0; k--) begin
        if (rot[k-1]) off = W'(k - 1);
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (rot[k]) off = W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum > LAST) sum = sum - SPAN;
    idx = sum[W-1:0];
  end

endmodule

// File: rtl/prio_irq_enc.sv
// Registered priority interrupt encoder: latches request lines, masks them,
// and presents one granted index at a time through a valid/ack handshake.
module prio_irq_enc
  import prio_irq_enc_pkg::*;
#(
  parameter  int unsigned N  = 8,
  parameter  int unsigned RR = MODE_FIXED,
  localparam int unsigned W  = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EN,
  input  logic [N-1:0] Din,
  input  logic [N-1:0] mask,
  output logic [W-1:0] Y,
  output logic         valid,
  input  logic         ack,
  output logic [N-1:0] pending
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [N-1:0] ONE      = N'(1);

  state_t       state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         valid_q, valid_d;
  logic [N-1:0] cand, clr, pend_d;
  logic [W-1:0] pick_idx;
  logic         pick_any;

  assign cand  = pending & mask;
  assign Y     = y_q;
  assign valid = valid_q;

  prio_pick #(
    .N  (N),
    .W  (W),
    .RR (RR)
  ) u_pick (
    .cand (cand),
    .ptr  (ptr_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        y_d     = '0;
        if (EN && pick_any) begin
          state_d = PRESENT;
          valid_d = 1'b1;
          y_d     = pick_idx;
        end
      end
      PRESENT: begin
        if (ack) begin
          clr     = ONE << y_q;
          state_d = IDLE;
          valid_d = 1'b0;
          y_d     = '0;
          if (RR == MODE_RR) ptr_d = (y_q == LAST_IDX) ? '0 : y_q + 1'b1;
        end else if (!EN) begin
          state_d = IDLE;
          valid_d = 1'b0;
          y_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        y_d     = '0;
      end
    endcase
    // A new request on the bit being cleared wins over the clear.
    pend_d = (pending & ~clr) | Din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      pending <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      pending <= pend_d;
    end
  end

endmodule

// File: tb/tb_prio_irq_enc.sv
// Scoreboard bench: three encoder configurations driven by shared stimulus,
// each compared against a high-level model of the grant rules.
module tb_prio_irq_enc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] mask = '0;

  logic       v_o [3];
  logic [2:0] y_o [3];
  logic [7:0] p_f, p_r;
  logic [4:0] p_5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prio_irq_enc #(.N(8), .RR(0)) dut_f (
    .clk(clk), .rst(rst), .EN(en), .Din(din), .mask(mask),
    .Y(y_o[0]), .valid(v_o[0]), .ack(ack), .pending(p_f));

  prio_irq_enc #(.N(8), .RR(1)) dut_r (
    .clk(clk), .rst(rst), .EN(en), .Din(din), .mask(mask),
    .Y(y_o[1]), .valid(v_o[1]), .ack(ack), .pending(p_r));

  prio_irq_enc #(.N(5), .RR(1)) dut_5 (
    .clk(clk), .rst(rst), .EN(en), .Din(din[4:0]), .mask(mask[4:0]),
    .Y(y_o[2]), .valid(v_o[2]), .ack(ack), .pending(p_5));

  // ---------------- reference model ----------------
  int unsigned cfg_n  [3] = '{8, 8, 5};
  bit          cfg_rr [3] = '{1'b0, 1'b1, 1'b1};
  bit [7:0]    m_pend [3];
  bit          m_v    [3];
  int unsigned m_y    [3];
  int unsigned m_ptr  [3];
  int unsigned q0[$], q1[$], q2[$];

  function automatic void chk(string name, logic [31:0] act, int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void qpush(int c, int unsigned v);
    case (c)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int qsize(int c);
    case (c)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int unsigned qpop(int c);
    case (c)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Fixed: highest requesting index. Round-robin: first requester at or after ptr.
  function automatic int unsigned pick(int c, bit [7:0] cand);
    int n;
    n = int'(cfg_n[c]);
    if (!cfg_rr[c]) begin
      for (int i = n - 1; i >= 0; i--) if (cand[i]) return i;
    end else begin
      for (int k = 0; k < n; k++) begin
        int unsigned i;
        i = (m_ptr[c] + k) % n;
        if (cand[i]) return i;
      end
    end
    return 0;
  endfunction

  function automatic void model_step(int c);
    bit [7:0] nm, cand, clr;
    nm   = (cfg_n[c] == 8) ? 8'hFF : 8'h1F;
    cand = m_pend[c] & mask & nm;
    clr  = '0;
    if (rst) begin
      m_pend[c] = '0; m_v[c] = 1'b0; m_y[c] = 0; m_ptr[c] = 0;
      return;
    end
    if (!m_v[c]) begin
      if (en && cand != 0) begin
        m_y[c] = pick(c, cand);
        m_v[c] = 1'b1;
        qpush(c, m_y[c]);
      end
    end else if (ack) begin
      clr[m_y[c]] = 1'b1;
      if (cfg_rr[c]) m_ptr[c] = (m_y[c] + 1) % cfg_n[c];
      m_v[c] = 1'b0;
      m_y[c] = 0;
    end else if (!en) begin
      m_v[c] = 1'b0;
      m_y[c] = 0;
    end
    m_pend[c] = (m_pend[c] & ~clr) | (din & nm);
  endfunction

  function automatic logic [7:0] get_p(int c);
    case (c)
      0: return p_f;
      1: return p_r;
      default: return {3'b000, p_5};
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic        prev_v [3] = '{1'b0, 1'b0, 1'b0};
  int unsigned exp_y  [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("valid[%0d]", c), 32'(v_o[c]), 32'(m_v[c]));
      chk($sformatf("pending[%0d]", c), 32'(get_p(c)), 32'(m_pend[c]));
      if (v_o[c] === 1'b1 && prev_v[c] !== 1'b1) begin
        if (qsize(c) == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL grant[%0d]: got Y=%0d, required no grant (t=%0t)", c, y_o[c], $time);
        end else begin
          exp_y[c] = qpop(c);
          chk($sformatf("grant[%0d]", c), 32'(y_o[c]), exp_y[c]);
        end
      end else if (v_o[c] === 1'b1) begin
        chk($sformatf("hold[%0d]", c), 32'(y_o[c]), exp_y[c]);
      end else begin
        chk($sformatf("y_idle[%0d]", c), 32'(y_o[c]), 0);
      end
      prev_v[c] = v_o[c];
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    for (int c = 0; c < 3; c++) model_step(c);
    #1;
  endtask

  task automatic wait_valid(int c, string name);
    for (int i = 0; i < 8 && v_o[c] !== 1'b1; i++) tick();
    chk(name, 32'(v_o[c]), 1);
  endtask

  task automatic do_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      m_pend[c] = '0; m_v[c] = 1'b0; m_y[c] = 0; m_ptr[c] = 0;
    end
    rst = 1'b1; tick(); tick();
    chk("reset_valid", 32'(v_o[0]), 0);
    chk("reset_pending", 32'(p_f), 0);
    rst = 1'b0; en = 1'b1; mask = 8'hFF; tick();

    // Two requests together, a late request while presenting.
    din = 8'b0010_0100; tick(); din = '0; tick();
    chk("fix_first_valid", 32'(v_o[0]), 1);
    chk("fix_first_y5", 32'(y_o[0]), 5);
    do_ack(); tick();
    chk("fix_second_y2", 32'(y_o[0]), 2);
    din = 8'h80; tick(); din = '0; tick();
    chk("fix_hold_y2", 32'(y_o[0]), 2);
    do_ack(); tick();
    chk("fix_late_y7", 32'(y_o[0]), 7);
    do_ack(); tick(); tick();
    chk("fix_drained_valid", 32'(v_o[0]), 0);
    chk("fix_drained_pend", 32'(p_f), 0);

    // Round-robin over all lines, then wrap.
    rst = 1'b1; tick(); rst = 1'b0;
    din = 8'hFF; tick(); din = '0;
    for (int k = 0; k < 8; k++) begin
      wait_valid(1, "rr_wait");
      chk($sformatf("rr_seq%0d", k), 32'(y_o[1]), k);
      do_ack();
    end
    din = 8'h09; tick(); din = '0;
    wait_valid(1, "rr_wait");
    chk("rr_wrap_y0", 32'(y_o[1]), 0);
    do_ack();
    wait_valid(1, "rr_wait");
    chk("rr_wrap_y3", 32'(y_o[1]), 3);
    do_ack();

    // Masked lines still latch; withdraw on EN low; set beats clear.
    rst = 1'b1; tick(); rst = 1'b0;
    mask = 8'h0F; din = 8'hF0; tick(); din = '0;
    repeat (4) tick();
    chk("mask_no_valid", 32'(v_o[0]), 0);
    chk("mask_pending", 32'(p_f), 32'h00F0);
    mask = 8'hFF;
    wait_valid(0, "unmask_wait");
    chk("unmask_y7", 32'(y_o[0]), 7);
    en = 1'b0; tick();
    chk("withdraw_valid", 32'(v_o[0]), 0);
    chk("withdraw_pend", 32'(p_f), 32'h00F0);
    en = 1'b1;
    wait_valid(0, "regrant_wait");
    chk("regrant_y7", 32'(y_o[0]), 7);
    ack = 1'b1; din = 8'h80; tick(); ack = 1'b0; din = '0;
    chk("setwins_pend", 32'(p_f), 32'h00F0);
    wait_valid(0, "setwins_wait");
    chk("setwins_y7", 32'(y_o[0]), 7);

    // N=5 round-robin wrap from pointer 4, then reset mid-grant.
    rst = 1'b1; tick(); rst = 1'b0;
    din = 8'h08; tick(); din = '0;
    wait_valid(2, "n5_wait");
    chk("n5_y3", 32'(y_o[2]), 3);
    do_ack();
    din = 8'h03; tick(); din = '0;
    wait_valid(2, "n5_wait");
    chk("n5_wrap_y0", 32'(y_o[2]), 0);
    do_ack();
    wait_valid(2, "n5_wait");
    chk("n5_y1", 32'(y_o[2]), 1);
    din = 8'h04; tick(); din = '0;
    rst = 1'b1; tick();
    chk("rst_mid_valid", 32'(v_o[2]), 0);
    chk("rst_mid_pend", 32'(p_5), 0);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      din  = 8'($urandom & $urandom & $urandom);
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      en   = ($urandom_range(0, 9) != 0);
      ack  = ($urandom_range(0, 1) == 1);
      rst  = ($urandom_range(0, 149) == 0);
      tick();
    end
    din = '0; ack = 1'b0; rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) chk($sformatf("sb_leftover[%0d]", c), 32'(qsize(c)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
